// File: rtl/freq_codec_gen2.sv
// freq_codec_gen2 -- frequency encoder/decoder pair.
//   Encoder: DATA_W-bit word -> 50% duty square wave, half-period = word (in enabled cycles).
//   Decoder: counts synchronised rising edges of pulse_in over a GATE_CYCLES window.
// Latency: encoder half-period changes at the next half-period boundary; decoder input
//   latency SYNC_STAGES+1 cycles, rx_valid one cycle after the last window cycle.
// Backpressure: none; rx_valid is a one-cycle strobe that must be captured when seen.
// Ports: clk, reset (async, active high), enable (run/abort), tx_data/tx_load (encoder word
//   and shadow load), pulse_out (encoded wave), pulse_in (async decoder input),
//   rx_data/rx_valid/rx_ovf (window result, strobe, overflow).
// Optional build macro FREQ_CODEC_LOOPBACK_EN adds input 'loopback' which routes pulse_out
//   into the decoder synchroniser in place of pulse_in.
module freq_codec_gen2 #(
   parameter int DATA_W      = 8,
   parameter int GATE_CYCLES = 10_000_000,
   parameter int GATE_W      = 24,
   parameter int SYNC_STAGES = 2
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              enable,
   input  logic [DATA_W-1:0] tx_data,
   input  logic              tx_load,
`ifdef FREQ_CODEC_LOOPBACK_EN
   input  logic              loopback,
`endif
   output logic              pulse_out,
   input  logic              pulse_in,
   output logic [DATA_W-1:0] rx_data,
   output logic              rx_valid,
   output logic              rx_ovf
);

   localparam logic [DATA_W-1:0] ONE_D     = DATA_W'(1);
   localparam logic [DATA_W-1:0] SAT_D     = '1;
   localparam logic [GATE_W-1:0] ONE_G     = GATE_W'(1);
   localparam logic [GATE_W-1:0] GATE_LAST = GATE_W'(GATE_CYCLES - 1);

   // ---------------- encoder ----------------
   logic [DATA_W-1:0] shadow;
   logic [DATA_W-1:0] active;
   logic [DATA_W-1:0] half_cnt;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         shadow    <= '0;
         active    <= '0;
         half_cnt  <= '0;
         pulse_out <= 1'b0;
      end else begin
         if (tx_load)
            shadow <= tx_data;
         if (enable) begin
            if (active == '0) begin
               // idle encoder picks up a new word immediately
               active    <= shadow;
               half_cnt  <= '0;
               pulse_out <= 1'b0;
            end else if (half_cnt == active - ONE_D) begin
               // half-period boundary: the only place the period may change
               half_cnt  <= '0;
               active    <= shadow;
               pulse_out <= (shadow == '0) ? 1'b0 : ~pulse_out;
            end else begin
               half_cnt <= half_cnt + ONE_D;
            end
         end
      end
   end

   // ---------------- decoder input ----------------
   logic dec_in;
`ifdef FREQ_CODEC_LOOPBACK_EN
   assign dec_in = loopback ? pulse_out : pulse_in;
`else
   assign dec_in = pulse_in;
`endif

   logic [SYNC_STAGES-1:0] sync_ff;
   logic                   sync_d;
   logic                   rise;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         sync_ff <= '0;
         sync_d  <= 1'b0;
      end else begin
         sync_ff <= {sync_ff[SYNC_STAGES-2:0], dec_in};
         sync_d  <= sync_ff[SYNC_STAGES-1];
      end
   end

   assign rise = sync_ff[SYNC_STAGES-1] & ~sync_d;

   // ---------------- decoder FSM ----------------
   typedef enum logic {IDLE, GATE} state_t;
   state_t state, state_nxt;

   logic [GATE_W-1:0] gate_cnt;
   logic [DATA_W-1:0] edge_cnt;
   logic              ovf_flag;
   logic              win_end;
   logic [DATA_W-1:0] cnt_next;
   logic              ovf_next;

   // saturating edge count including the current cycle's edge
   assign cnt_next = (rise && edge_cnt != SAT_D) ? edge_cnt + ONE_D : edge_cnt;
   assign ovf_next = ovf_flag | (rise & (edge_cnt == SAT_D));

   always_ff @(posedge clk or posedge reset) begin
      if (reset)
         state <= IDLE;
      else
         state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      win_end   = 1'b0;
      case (state)
         IDLE: if (enable) state_nxt = GATE;
         GATE: begin
            if (!enable)
               state_nxt = IDLE;
            else if (gate_cnt == GATE_LAST)
               win_end = 1'b1;
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         gate_cnt <= '0;
         edge_cnt <= '0;
         ovf_flag <= 1'b0;
         rx_data  <= '0;
         rx_ovf   <= 1'b0;
         rx_valid <= 1'b0;
      end else begin
         rx_valid <= 1'b0;
         if (state == GATE && enable && !win_end) begin
            gate_cnt <= gate_cnt + ONE_G;
            edge_cnt <= cnt_next;
            ovf_flag <= ovf_next;
         end else begin
            // idle, aborted window, or window end: next window starts from zero
            gate_cnt <= '0;
            edge_cnt <= '0;
            ovf_flag <= 1'b0;
         end
         if (win_end) begin
            rx_data  <= cnt_next;
            rx_ovf   <= ovf_next;
            rx_valid <= 1'b1;
         end
      end
   end

endmodule
